uart_rx_fifo: RTL and testbench

Receive-side byte buffer sitting directly downstream of the UART receiver.
- Detects the receiver's level-held ready flag, captures the byte into a circular FIFO, and pulses the clear handshake back to the receiver.
- Presents a first-word-fall-through read port to the consuming logic (CPU bridge / command parser).
- Decouples bursty UART arrivals from a slow consumer.
- Flags dropped bytes with a sticky overflow bit.

---
 rtl/uart_rx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: captures held-ready UART bytes into a circular FIFO with FWFT read port.
// Latency: a byte captured on edge N is visible on rd_data/empty in the cycle after edge N.
// Backpressure: none toward the receiver; a byte arriving while full (and no pop) is dropped and flagged.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  output logic                  rx_ready_clear,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  overflow_clear
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_ready_clear_q, rx_ready_clear_d;
  logic                  push_req;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  fifo_empty, fifo_full;
  logic                  do_pop, do_push, do_drop;

  // Ack FSM state and registered clear handshake
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      rx_ready_clear_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      rx_ready_clear_q <= rx_ready_clear_d;
    end
  end

  // Ack FSM next state: leave IDLE on a ready byte, return once ready has dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_ready)  state_d = S_ACK;
      S_ACK:   if (!rx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ack FSM outputs: a byte is taken only on IDLE->ACK; clear follows ready while acknowledging
  always_comb begin
    push_req         = 1'b0;
    rx_ready_clear_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        push_req         = rx_ready;
        rx_ready_clear_d = rx_ready;
      end
      S_ACK: begin
        rx_ready_clear_d = rx_ready;
      end
      default: begin
        push_req         = 1'b0;
        rx_ready_clear_d = 1'b0;
      end
    endcase
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  // FIFO control: a pop on a full FIFO frees the slot the incoming byte needs
  always_comb begin
    do_pop     = rd_en && !fifo_empty;
    do_push    = push_req && (!fifo_full || do_pop);
    do_drop    = push_req && fifo_full && !do_pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
    // a drop in the same cycle as a clear request must stay visible
    if (do_drop)             overflow_d = 1'b1;
    else if (overflow_clear) overflow_d = 1'b0;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage has no reset; contents are only observed through a valid head
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rx_ready_clear = rx_ready_clear_q;
  assign rd_data        = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign empty          = fifo_empty;
  assign full           = fifo_full;
  assign count          = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: receiver handshake model plus byte scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled at that point too.
// Occupancy and overflow are tracked by a small model independent of the DUT.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       sys_clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ready_clear;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       overflow_clear;

  int         tests_run;
  int         tests_failed;
  int         mc;
  bit         exp_ov;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .rx_ready_clear (rx_ready_clear),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // One receiver byte: ready held until clear seen (+extra cycles), optional pop / overflow_clear alongside
  task automatic send_byte(input logic [7:0] b, input int extra, input bit with_pop, input bit ovc);
    int         clr_hi;
    bit         popped;
    bit         accepted;
    logic [7:0] dummy;
    clr_hi         = 0;
    rx_data        = b;
    rx_ready       = 1'b1;
    rd_en          = with_pop;
    overflow_clear = ovc;
    popped         = with_pop && (mc > 0);
    if (popped) begin
      tests_run++;
      if (rd_data !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL send_pop_head: rd_data got %02h exp %02h", rd_data, exp_q[0]);
      end
      dummy = exp_q.pop_front();
    end
    accepted = (mc - int'(popped)) < DEPTH;
    if (accepted) exp_q.push_back(b);
    mc = mc - int'(popped) + int'(accepted);
    if (!accepted)  exp_ov = 1'b1;
    else if (ovc)   exp_ov = 1'b0;
    @(posedge sys_clk); #1;
    rd_en          = 1'b0;
    overflow_clear = 1'b0;
    tests_run++;
    if (count !== 5'(mc)) begin
      tests_failed++;
      $display("FAIL send_count (byte %02h): got %0d exp %0d", b, count, mc);
    end
    tests_run++;
    if (overflow !== exp_ov) begin
      tests_failed++;
      $display("FAIL send_overflow (byte %02h): got %0b exp %0b", b, overflow, exp_ov);
    end
    if (rx_ready_clear === 1'b1) clr_hi++;
    for (int i = 0; i < extra; i++) begin
      @(posedge sys_clk); #1;
      if (rx_ready_clear === 1'b1) clr_hi++;
    end
    @(posedge sys_clk); #1;
    if (rx_ready_clear === 1'b1) clr_hi++;
    rx_ready = 1'b0;
    @(posedge sys_clk); #1;
    tests_run++;
    if (rx_ready_clear !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_release (byte %02h): got %0b exp 0", b, rx_ready_clear);
    end
    tests_run++;
    if (clr_hi != extra + 2) begin
      tests_failed++;
      $display("FAIL clear_dwell (byte %02h): got %0d cycles exp %0d", b, clr_hi, extra + 2);
    end
    tests_run++;
    if (count !== 5'(mc)) begin
      tests_failed++;
      $display("FAIL single_push (byte %02h): count got %0d exp %0d", b, count, mc);
    end
  endtask

  // Pop one byte and compare it to the scoreboard head
  task automatic pop_one();
    logic [7:0] exp_b;
    exp_b = exp_q.pop_front();
    tests_run++;
    if (rd_data !== exp_b || empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL pop_data: rd_data got %02h exp %02h (empty=%0b)", rd_data, exp_b, empty);
    end
    rd_en = 1'b1;
    @(posedge sys_clk); #1;
    rd_en = 1'b0;
    mc--;
    tests_run++;
    if (count !== 5'(mc)) begin
      tests_failed++;
      $display("FAIL pop_count: got %0d exp %0d", count, mc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_occupancy: count=%0d empty=%0b full=%0b exp 0/1/0", count, empty, full);
    end
    tests_run++;
    if (rd_data !== 8'h00 || rx_ready_clear !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rd_data=%02h clear=%0b overflow=%0b exp 00/0/0", rd_data, rx_ready_clear, overflow);
    end
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_single_byte();
    send_byte(8'hA5, 0, 1'b0, 1'b0);
    tests_run++;
    if (rd_data !== 8'hA5 || empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_head: rd_data=%02h empty=%0b exp A5/0", rd_data, empty);
    end
    pop_one();
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_empty: got %0b exp 1", empty);
    end
  endtask

  task automatic test_fill_order();
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 0, 1'b0, 1'b0);
    tests_run++;
    if (full !== 1'b1 || count !== 5'd16) begin
      tests_failed++;
      $display("FAIL fill_full: full=%0b count=%0d exp 1/16", full, count);
    end
    for (int i = 0; i < DEPTH; i++) pop_one();
    tests_run++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_empty: empty=%0b full=%0b exp 1/0", empty, full);
    end
    rd_en = 1'b1;
    @(posedge sys_clk); #1;
    rd_en = 1'b0;
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL pop_when_empty: count=%0d empty=%0b exp 0/1", count, empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), 0, 1'b0, 1'b0);
    send_byte(8'hFF, 0, 1'b0, 1'b0);
    overflow_clear = 1'b1;
    @(posedge sys_clk); #1;
    overflow_clear = 1'b0;
    exp_ov = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_clear: got %0b exp 0", overflow);
    end
    send_byte(8'hEE, 0, 1'b0, 1'b1);
    tests_run++;
    if (overflow !== 1'b1 || full !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_set_wins: overflow=%0b full=%0b exp 1/1", overflow, full);
    end
  endtask

  task automatic test_full_pop();
    send_byte(8'h55, 0, 1'b1, 1'b0);
    tests_run++;
    if (count !== 5'd16 || rd_data !== 8'h11) begin
      tests_failed++;
      $display("FAIL full_pop_head: count=%0d rd_data=%02h exp 16/11", count, rd_data);
    end
    for (int i = 0; i < DEPTH; i++) pop_one();
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_pop_drain: empty got %0b exp 1", empty);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h77, 0, 1'b1, 1'b0);
    send_byte(8'h78, 0, 1'b1, 1'b0);
    pop_one();
  endtask

  task automatic test_long_ready();
    send_byte(8'hC3, 8, 1'b0, 1'b0);
    pop_one();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 0, 1'b0, 1'b0);
    rx_data  = 8'h99;
    rx_ready = 1'b1;
    @(posedge sys_clk); #1;
    tests_run++;
    if (rx_ready_clear !== 1'b1 || count !== 5'd6) begin
      tests_failed++;
      $display("FAIL mid_ack_entry: clear=%0b count=%0d exp 1/6", rx_ready_clear, count);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1 || rx_ready_clear !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: count=%0d empty=%0b clear=%0b overflow=%0b exp 0/1/0/0",
               count, empty, rx_ready_clear, overflow);
    end
    mc     = 0;
    exp_ov = 1'b0;
    exp_q.delete();
    rx_data = 8'h3C;
    #1 rst_n = 1'b1;
    send_byte(8'h3C, 0, 1'b0, 1'b0);
    tests_run++;
    if (rd_data !== 8'h3C) begin
      tests_failed++;
      $display("FAIL reset_recapture: rd_data got %02h exp 3C", rd_data);
    end
    pop_one();
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    mc             = 0;
    exp_ov         = 1'b0;
    rx_data        = 8'h00;
    rx_ready       = 1'b0;
    rd_en          = 1'b0;
    overflow_clear = 1'b0;
    test_reset();
    test_single_byte();
    test_fill_order();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_long_ready();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
